vx_mem_responder: RTL and testbench
===================================

VX_MEM_RESPONDER -- requirements
Module: VX_mem_responder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, line size in bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, line-address width (memory depth = 2^ADDR_WIDTH lines).
REQ-003 SHALL have parameter TAG_WIDTH, default 8, request tag width echoed on responses.
REQ-004 SHALL have parameter LATENCY, default 4, read acceptance-to-queue delay in cycles (>=1).
REQ-005 SHALL have parameter RSP_QUEUE_SIZE, default 4, maximum outstanding reads (power of 2, >=2).
REQ-006 SHALL have ports, one clock, synchronous active-high reset:
  clk  input  1  clock
  reset  input  1  synchronous active-high reset
  req_valid  input  1  request valid
  req_rw  input  1  1=write, 0=read
  req_addr  input  ADDR_WIDTH  line address
  req_byteen  input  DATA_SIZE  write byte enables
  req_data  input  8*DATA_SIZE  write data
  req_tag  input  TAG_WIDTH  request tag
  req_ready  output  1  request accepted when valid&&ready
  rsp_valid  output  1  read response valid
  rsp_data  output  8*DATA_SIZE  read data
  rsp_tag  output  TAG_WIDTH  tag of originating read
  rsp_ready  input  1  response consumed when valid&&ready
  busy  output  1  reads in flight or queued

Function
REQ-007 SHALL be the slave end of the VX_mem_bus_if protocol: one request per cycle max; writes produce no response.
REQ-008 SHALL apply an accepted write in its acceptance cycle, updating only bytes with req_byteen[i]=1; byteen=0 is a legal no-op write.
REQ-009 SHALL sample memory for an accepted read at its acceptance clock edge; a read accepted the cycle after a write to the same address SHALL return the written data.
REQ-010 SHALL deliver each read into the response queue exactly LATENCY cycles after acceptance; with queue empty and rsp_ready=1, rsp_valid rises LATENCY cycles after acceptance.
REQ-011 SHALL return responses strictly in acceptance order, tag echoed unmodified.
REQ-012 SHALL hold rsp_valid, rsp_data, rsp_tag stable while rsp_valid=1 and rsp_ready=0.
REQ-013 SHALL keep a credit counter of reads in pipeline plus queue (0..RSP_QUEUE_SIZE); +1 on read accept, -1 on response handshake, unchanged when both occur in one cycle.
REQ-014 SHALL drive req_ready = (credits < RSP_QUEUE_SIZE) || (rsp_valid && rsp_ready), combinational; writes are gated by the same req_ready.
REQ-015 SHALL never overflow the queue: at credits=RSP_QUEUE_SIZE with no dequeue, req_ready=0.
REQ-016 SHALL drive busy = (credits != 0).
REQ-017 SHALL not depend on rsp_ready to advance the LATENCY pipeline (credits guarantee queue space).
REQ-018 SHALL use req_addr directly (no range check); all 2^ADDR_WIDTH lines addressable.

Reset
REQ-019 SHALL, while reset=1, drive req_ready=0, rsp_valid=0, busy=0, clear credits, pipeline valids and queue.
REQ-020 SHALL NOT clear memory contents; content before the first write is undefined.
REQ-021 SHALL discard in-flight and queued reads when reset asserts mid-operation; no stale response after reset.
REQ-022 SHALL assert req_ready=1 the first cycle after reset deasserts.

Structure
REQ-023 SHALL add no typedefs to VX_gpu_pkg; all widths derive locally from parameters.
REQ-024 SHALL instantiate VX_fifo_queue (depth RSP_QUEUE_SIZE, width 8*DATA_SIZE+TAG_WIDTH) as the response queue; latency pipe is an inline valid/tag/data shift register.

Verification
REQ-025 Write addr 5 data 0xA5 repeated, byteen all-1; read addr 5 tag 0x11, rsp_ready=1 -> rsp_valid exactly 4 cycles after accept, data all 0xA5, tag 0x11.
REQ-026 Write addr 7 all 0x00, then byteen 0x1 data 0xFF -> read addr 7 returns byte0=0xFF, others 0x00.
REQ-027 rsp_ready=0, issue 6 back-to-back reads -> 4 accepted, req_ready=0 from 5th, busy=1; release rsp_ready -> 4 responses in tag order, req_ready returns.
REQ-028 Queue full, rsp_ready=1, read presented -> accepted same cycle as dequeue, credits stay 4.
REQ-029 Reset pulse 1 cycle with 3 reads in flight -> no rsp_valid afterwards, busy=0, req_ready=1 next cycle, prior memory writes still readable.

Source files
------------

// File: rtl/vx_mem_responder_pkg.sv
// Shared definitions for the memory responder.
//   req_kind_e  : decodes the req_rw request bit (write vs read).
//   cnt_width() : width needed for a counter that reaches max_val inclusive.
// All data/tag/address widths are derived locally from module parameters.
package vx_mem_responder_pkg;

  typedef enum logic {
    ReqRead  = 1'b0,
    ReqWrite = 1'b1
  } req_kind_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vx_mem_responder_fifo_queue.sv
// Response queue for the memory responder: a power-of-two depth FIFO.
// Pointers carry one wrap bit so full and empty can be told apart.
// The head entry is presented on data_o whenever empty_o is low and stays
// put until pop_i.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset (clears pointers)
//   push_i, data_i : enqueue one entry (ignored when full)
//   pop_i          : dequeue the head entry (ignored when empty)
//   data_o         : head entry
//   empty_o        : queue holds no entries
module vx_mem_responder_fifo_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DATAW = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DATAW-1:0] data_i,
  output logic [DATAW-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [DATAW-1:0] mem_q [DEPTH];
  logic             full;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AddrW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AddrW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-bus slave model: a 2^ADDR_WIDTH-line memory with byte-enabled
// writes and fixed-latency, in-order read responses.
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   req_valid_i      : request valid; accepted when req_valid_i && req_ready_o
//   req_rw_i         : 1 = write, 0 = read
//   req_addr_i       : line address
//   req_byteen_i     : write byte enables (one per byte of the line)
//   req_data_i       : write data
//   req_tag_i        : request tag, echoed on the read response
//   req_ready_o      : request may be accepted this cycle
//   rsp_valid_o      : read response valid
//   rsp_data_o       : read data
//   rsp_tag_o        : tag of the originating read
//   rsp_ready_i      : response consumed when rsp_valid_o && rsp_ready_i
//   busy_o           : reads in flight or queued
// A read is sampled at its acceptance edge and reaches the response queue
// LATENCY cycles later. A credit counter covers pipeline plus queue, so the
// pipeline never has to stall on rsp_ready_i.
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_SIZE      = 64,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned RSP_QUEUE_SIZE = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   req_valid_i,
  input  logic                   req_rw_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [DATA_SIZE-1:0]   req_byteen_i,
  input  logic [8*DATA_SIZE-1:0] req_data_i,
  input  logic [TAG_WIDTH-1:0]   req_tag_i,
  output logic                   req_ready_o,
  output logic                   rsp_valid_o,
  output logic [8*DATA_SIZE-1:0] rsp_data_o,
  output logic [TAG_WIDTH-1:0]   rsp_tag_o,
  input  logic                   rsp_ready_i,
  output logic                   busy_o
);

  localparam int unsigned DataW  = 8 * DATA_SIZE;
  localparam int unsigned EntryW = DataW + TAG_WIDTH;
  localparam int unsigned CntW   = cnt_width(RSP_QUEUE_SIZE);
  localparam int unsigned Lines  = 1 << ADDR_WIDTH;
  localparam logic [CntW-1:0] CreditMax = CntW'(RSP_QUEUE_SIZE);

  logic [DataW-1:0]  mem_q [Lines];
  logic [DataW-1:0]  rd_data;

  logic              req_fire, write_fire, read_fire, rsp_fire;
  logic [CntW-1:0]   credits_q, credits_d;

  logic              q_push, q_empty;
  logic [EntryW-1:0] q_push_data, q_head;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign rsp_valid_o = !reset_i && !q_empty;
  assign rsp_fire    = rsp_valid_o && rsp_ready_i;

  // A full credit count still admits a request when a response leaves in the
  // same cycle; writes share this gate even though they use no credit.
  assign req_ready_o = !reset_i && ((credits_q < CreditMax) || rsp_fire);
  assign req_fire    = req_valid_i && req_ready_o;
  assign write_fire  = req_fire && (req_kind_e'(req_rw_i) == ReqWrite);
  assign read_fire   = req_fire && (req_kind_e'(req_rw_i) == ReqRead);

  assign busy_o      = !reset_i && (credits_q != '0);

  assign rsp_data_o  = q_head[DataW-1:0];
  assign rsp_tag_o   = q_head[EntryW-1:DataW];

  // ---------------------------------------------------------------------------
  // Credits: reads in the latency pipe plus entries in the response queue
  // ---------------------------------------------------------------------------
  always_comb begin
    credits_d = credits_q;
    case ({read_fire, rsp_fire})
      2'b10:   credits_d = credits_q + CntW'(1);
      2'b01:   credits_d = credits_q - CntW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_q <= '0;
    end else begin
      credits_q <= credits_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array: not reset, contents survive reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (write_fire) begin
      for (int i = 0; i < int'(DATA_SIZE); i++) begin
        if (req_byteen_i[i]) mem_q[req_addr_i][i*8 +: 8] <= req_data_i[i*8 +: 8];
      end
    end
  end

  // Combinational read, captured at the acceptance edge. A write and a read
  // can never share a cycle, so a read one cycle after a write sees its data.
  assign rd_data = mem_q[req_addr_i];

  // ---------------------------------------------------------------------------
  // Latency pipe: LATENCY-1 register stages; the queue itself is the last one
  // ---------------------------------------------------------------------------
  if (LATENCY <= 1) begin : g_no_pipe
    assign q_push      = read_fire;
    assign q_push_data = {req_tag_i, rd_data};
  end else begin : g_pipe
    localparam int unsigned Stages = LATENCY - 1;

    logic [Stages-1:0] vld_q;
    logic [EntryW-1:0] ent_q [Stages];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= read_fire;
        for (int i = 1; i < int'(Stages); i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (read_fire) ent_q[0] <= {req_tag_i, rd_data};
      for (int i = 1; i < int'(Stages); i++) begin
        if (vld_q[i-1]) ent_q[i] <= ent_q[i-1];
      end
    end

    assign q_push      = vld_q[Stages-1];
    assign q_push_data = ent_q[Stages-1];
  end

  // ---------------------------------------------------------------------------
  // Response queue
  // ---------------------------------------------------------------------------
  vx_mem_responder_fifo_queue #(
    .DEPTH (RSP_QUEUE_SIZE),
    .DATAW (EntryW)
  ) u_rsp_queue (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (q_push),
    .pop_i   (rsp_fire),
    .data_i  (q_push_data),
    .data_o  (q_head),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_vx_mem_responder.sv
module tb_vx_mem_responder;

  localparam int DS  = 64;
  localparam int AW  = 10;
  localparam int TW  = 8;
  localparam int LAT = 4;
  localparam int QS  = 4;
  localparam int DW  = 8 * DS;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_rw;
  logic [AW-1:0] req_addr;
  logic [DS-1:0] req_byteen;
  logic [DW-1:0] req_data;
  logic [TW-1:0] req_tag;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ready;
  logic          busy;

  vx_mem_responder #(
    .DATA_SIZE      (DS),
    .ADDR_WIDTH     (AW),
    .TAG_WIDTH      (TW),
    .LATENCY        (LAT),
    .RSP_QUEUE_SIZE (QS)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_rw_i     (req_rw),
    .req_addr_i   (req_addr),
    .req_byteen_i (req_byteen),
    .req_data_i   (req_data),
    .req_tag_i    (req_tag),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_tag_o    (rsp_tag),
    .rsp_ready_i  (rsp_ready),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: memory image plus the list of accepted reads, each with
  // the cycle from which it may appear at the response port.
  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            rdy;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [1 << AW];
  int            cyc;
  int            errors;
  int            checks;

  logic          obs_ready, obs_valid, obs_busy;
  logic [DW-1:0] obs_data;
  logic [TW-1:0] obs_tag;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DS-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DS; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic idle();
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_byteen = '0;
    req_data   = '0;
    req_tag    = '0;
  endtask

  task automatic set_write(input int addr, input logic [DW-1:0] d, input logic [DS-1:0] be);
    req_valid  = 1'b1;
    req_rw     = 1'b1;
    req_addr   = AW'(addr);
    req_data   = d;
    req_byteen = be;
  endtask

  task automatic set_read(input int addr, input logic [TW-1:0] tag);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = AW'(addr);
    req_tag   = tag;
  endtask

  // One clock cycle: compare the DUT port state against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic step();
    logic ev, er, eb;
    exp_t e;
    @(negedge clk);
    ev = !reset && exp_q.size() > 0 && cyc >= exp_q[0].rdy;
    er = !reset && (exp_q.size() < QS || (ev && rsp_ready));
    eb = !reset && exp_q.size() != 0;
    checks += 3;
    if (rsp_valid !== ev) begin
      errors++;
      $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev);
    end
    if (req_ready !== er) begin
      errors++;
      $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
    end
    if (busy !== eb) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
    end
    if (ev) begin
      checks += 2;
      if (rsp_tag !== exp_q[0].tag) begin
        errors++;
        $display("FAIL rsp_tag cyc=%0d got=%h exp=%h", cyc, rsp_tag, exp_q[0].tag);
      end
      if (rsp_data !== exp_q[0].data) begin
        errors++;
        $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_q[0].data);
      end
    end
    obs_ready = req_ready;
    obs_valid = rsp_valid;
    obs_busy  = busy;
    obs_data  = rsp_data;
    obs_tag   = rsp_tag;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
    end else begin
      if (ev && rsp_ready) e = exp_q.pop_front();
      if (er && req_valid) begin
        if (req_rw) begin
          ref_mem[req_addr] = merge(ref_mem[req_addr], req_data, req_byteen);
        end else begin
          e.data = ref_mem[req_addr];
          e.tag  = req_tag;
          e.rdy  = cyc + LAT;
          exp_q.push_back(e);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    set_read(3, 8'h01);
    repeat (3) step();
    checks++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b exp=000", obs_ready, obs_valid, obs_busy);
    end
    idle();
    reset = 1'b0;
    step();
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b exp=1", obs_ready);
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] pat;
    int k;
    pat = {DS{8'hA5}};
    rsp_ready = 1'b1;
    set_write(5, pat, {DS{1'b1}});
    step();
    set_read(5, 8'h11);
    step();
    idle();
    k = 0;
    do begin
      step();
      k++;
    end while (!obs_valid && k < 12);
    checks += 3;
    if (k != LAT) begin
      errors++;
      $display("FAIL read_latency got=%0d exp=%0d", k, LAT);
    end
    if (obs_data !== pat) begin
      errors++;
      $display("FAIL latency_data got=%h exp=%h", obs_data, pat);
    end
    if (obs_tag !== 8'h11) begin
      errors++;
      $display("FAIL latency_tag got=%h exp=11", obs_tag);
    end
    step();
  endtask

  task automatic test_byteen();
    logic [DW-1:0] expd;
    int k;
    expd = '0;
    expd[7:0] = 8'hFF;
    rsp_ready = 1'b1;
    set_write(7, '0, {DS{1'b1}});
    step();
    set_write(7, {DS{8'hFF}}, 64'h1);
    step();
    set_write(7, {DS{8'h3C}}, '0);  // byte-enable-free write must change nothing
    step();
    set_read(7, 8'h22);
    step();
    idle();
    k = 0;
    do begin
      step();
      k++;
    end while (!obs_valid && k < 12);
    checks++;
    if (obs_data !== expd || !obs_valid) begin
      errors++;
      $display("FAIL byteen_data valid=%b got=%h exp=%h", obs_valid, obs_data, expd);
    end
    step();
  endtask

  task automatic test_backpressure();
    int acc, got;
    logic [TW-1:0] want;
    acc = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_read(5, TW'(8'h30 + acc));
      step();
      if (obs_ready) acc++;
    end
    idle();
    step();
    checks += 3;
    if (acc != QS) begin
      errors++;
      $display("FAIL bp_accepted got=%0d exp=%0d", acc, QS);
    end
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low got=%b exp=0", obs_ready);
    end
    if (obs_busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_busy got=%b exp=1", obs_busy);
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs_valid) begin
        want = TW'(8'h30 + got);
        checks++;
        if (obs_tag !== want) begin
          errors++;
          $display("FAIL bp_order got=%h exp=%h", obs_tag, want);
        end
        got++;
      end
    end
    checks += 2;
    if (got != QS) begin
      errors++;
      $display("FAIL bp_rsp_count got=%0d exp=%0d", got, QS);
    end
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_back got=%b exp=1", obs_ready);
    end
  endtask

  task automatic test_full_dequeue();
    int k;
    rsp_ready = 1'b0;
    for (int i = 0; i < QS; i++) begin
      set_read(5, TW'(8'h40 + i));
      step();
    end
    idle();
    k = 0;
    do begin
      step();
      k++;
    end while (!obs_valid && k < 12);
    set_read(7, 8'h44);
    rsp_ready = 1'b1;
    step();
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_dequeue_accept got=%b exp=1", obs_ready);
    end
    idle();
    rsp_ready = 1'b0;
    step();
    checks++;
    if (obs_ready !== 1'b0 || obs_busy !== 1'b1) begin
      errors++;
      $display("FAIL full_credits_held ready=%b busy=%b exp ready=0 busy=1", obs_ready, obs_busy);
    end
    rsp_ready = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_reset_midflight();
    int stale, k;
    logic [DW-1:0] pat;
    pat = {DS{8'hA5}};
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_read(5, TW'(8'h50 + i));
      step();
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks += 2;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready got=%b exp=1", obs_ready);
    end
    if (obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy got=%b exp=0", obs_busy);
    end
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midreset_stale got=%0d exp=0", stale);
    end
    set_read(5, 8'h5A);
    step();
    idle();
    k = 0;
    do begin
      step();
      k++;
    end while (!obs_valid && k < 12);
    checks++;
    if (obs_data !== pat || !obs_valid) begin
      errors++;
      $display("FAIL midreset_mem valid=%b got=%h exp=%h", obs_valid, obs_data, pat);
    end
    step();
  endtask

  task automatic test_random();
    rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      set_write(a, {16{$urandom}}, {DS{1'b1}});
      step();
    end
    for (int n = 0; n < 600; n++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_rw     = ($urandom_range(0, 9) < 3);
      req_addr   = AW'($urandom_range(0, 15));
      req_byteen = {$urandom, $urandom};
      req_data   = {16{$urandom}};
      req_tag    = TW'($urandom);
      rsp_ready  = ($urandom_range(0, 9) < 7);
      step();
    end
    idle();
    rsp_ready = 1'b1;
    repeat (15) step();
    checks++;
    if (obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL random_drain_busy got=%b exp=0", obs_busy);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    reset     = 1'b1;
    rsp_ready = 1'b0;
    idle();
    test_reset();
    test_latency();
    test_byteen();
    test_backpressure();
    test_full_dequeue();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
